// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  localparam int unsigned MAX_N = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width helper that never returns zero, so single-value counters stay legal.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int unsigned id, input int unsigned n);
    logic [MAX_N-1:0] r;
    r = '0;
    if (id < n) r[id] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or after start_i, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2_min1(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] start_i,
  output logic [ID_W-1:0] win_id_o,
  output logic            win_valid_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;

  // Duplicate the request vector, blank bits below start, take the lowest survivor.
  always_comb begin
    dbl         = {req_i, req_i};
    mask        = '0;
    for (int i = 0; i < 2*N; i++) mask[i] = (i >= int'(start_i));
    masked      = dbl & mask;
    win_id_o    = '0;
    win_valid_o = 1'b0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) begin
        win_valid_o = 1'b1;
        win_id_o    = ID_W'(i % N);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant and bounded grant hold.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  localparam int ID_W     = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    request,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  localparam int HOLD_W    = clog2_min1(MAX_HOLD + 1);
  localparam int HOLD_LIM  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam bit UNLIMITED = (MAX_HOLD == 0);

  arb_state_e        state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              valid_q;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [ID_W-1:0]   start;
  logic [N-1:0]      pick_req;
  logic              owner_req;
  logic [ID_W-1:0]   win_id;
  logic              win_valid;

  // Search starts after the last winner; the current owner is excluded so it ranks last.
  always_comb begin
    start     = (last_q == ID_W'(N-1)) ? '0 : last_q + 1'b1;
    pick_req  = request;
    owner_req = request[id_q];
    if (state_q == GRANT) pick_req[id_q] = 1'b0;
  end

  rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .req_i       (pick_req),
    .start_i     (start),
    .win_id_o    (win_id),
    .win_valid_o (win_valid)
  );

  // Next-state: keep, rotate, hand over or release the grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_valid) begin
          state_d = GRANT;
          grant_d = N'(onehot(int'(win_id), N));
          id_d    = win_id;
          last_d  = win_id;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (owner_req) begin
          if (UNLIMITED || hold_q < HOLD_W'(HOLD_LIM)) begin
            if (!UNLIMITED) hold_d = hold_q + 1'b1;
          end else if (win_valid) begin
            grant_d = N'(onehot(int'(win_id), N));
            id_d    = win_id;
            last_d  = win_id;
            hold_d  = '0;
          end
        end else if (win_valid) begin
          grant_d = N'(onehot(int'(win_id), N));
          id_d    = win_id;
          last_d  = win_id;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      last_q  <= ID_W'(N-1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= |grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench: a 4-way/hold-4 arbiter and a 3-way/unlimited arbiter driven side by side.
module tb_rr_arbiter_n;

  typedef struct {
    logic [3:0] g;
    logic       v;
    logic [1:0] id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req4 = '0;
  logic [2:0] req3 = '0;
  logic [3:0] grant4;
  logic       valid4;
  logic [1:0] id4;
  logic [2:0] grant3;
  logic       valid3;
  logic [1:0] id3;

  int   n_checks = 0;
  int   n_err    = 0;
  string phase   = "reset";

  exp_t q4[$];
  exp_t q3[$];

  bit m_own[2];
  int m_gid[2];
  int m_last[2];
  int m_hold[2];

  always #5 clk = ~clk;

  rr_arbiter_n #(.N(4), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .request(req4),
    .grant(grant4), .grant_valid(valid4), .grant_id(id4)
  );

  rr_arbiter_n #(.N(3), .MAX_HOLD(0)) u_dut3 (
    .clk(clk), .rst(rst), .request(req3),
    .grant(grant3), .grant_valid(valid3), .grant_id(id3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s got %0h exp %0h", phase, tag, got, exp);
    end
  endtask

  function automatic int rr_search(input int n, input logic [3:0] r, input int after);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (after + k) % n;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = 1'b0;
      m_gid[k]  = 0;
      m_hold[k] = 0;
    end
    m_last[0] = 3;
    m_last[1] = 2;
    q4.delete();
    q3.delete();
  endtask

  task automatic model_step(input int k, input int n, input int mh, input logic [3:0] r);
    int   p;
    exp_t e;
    logic [3:0] others;
    if (!m_own[k]) begin
      p = rr_search(n, r, m_last[k]);
      if (p >= 0) begin
        m_own[k] = 1'b1; m_gid[k] = p; m_last[k] = p; m_hold[k] = 0;
      end
    end else begin
      others = r;
      others[m_gid[k]] = 1'b0;
      p = rr_search(n, others, m_gid[k]);
      if (r[m_gid[k]]) begin
        if (mh == 0 || m_hold[k] < mh - 1) m_hold[k]++;
        else if (p >= 0) begin
          m_gid[k] = p; m_last[k] = p; m_hold[k] = 0;
        end
      end else if (p >= 0) begin
        m_gid[k] = p; m_last[k] = p; m_hold[k] = 0;
      end else begin
        m_own[k] = 1'b0; m_hold[k] = 0;
      end
    end
    e.g  = m_own[k] ? (4'b0001 << m_gid[k]) : 4'b0000;
    e.v  = m_own[k];
    e.id = 2'(m_gid[k]);
    if (k == 0) q4.push_back(e);
    else        q3.push_back(e);
  endtask

  task automatic sb_empty(input string tag);
    n_checks++;
    n_err++;
    $display("FAIL %s/%s scoreboard empty", phase, tag);
  endtask

  task automatic cycle(input logic [3:0] r4, input logic [2:0] r3);
    exp_t e;
    @(negedge clk);
    req4 = r4;
    req3 = r3;
    model_step(0, 4, 4, r4);
    model_step(1, 3, 0, {1'b0, r3});
    @(posedge clk);
    #1;
    if (q4.size() == 0) sb_empty("q4");
    else begin
      e = q4.pop_front();
      chk("grant4", 32'(grant4), 32'(e.g));
      chk("valid4", 32'(valid4), 32'(e.v));
      chk("id4",    32'(id4),    32'(e.id));
    end
    if (q3.size() == 0) sb_empty("q3");
    else begin
      e = q3.pop_front();
      chk("grant3", 32'(grant3), 32'(e.g[2:0]));
      chk("valid3", 32'(valid3), 32'(e.v));
      chk("id3",    32'(id3),    32'(e.id));
    end
    chk("onehot3", 32'($onehot0(grant3)), 32'd1);
    chk("subset3", 32'(grant3 & ~r3), 32'd0);
  endtask

  initial begin
    logic [3:0] r4;
    logic [2:0] r3;
    model_reset();
    #12;
    chk("rst_grant4", 32'(grant4), 32'd0);
    chk("rst_valid4", 32'(valid4), 32'd0);
    chk("rst_id4",    32'(id4),    32'd0);
    chk("rst_grant3", 32'(grant3), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    phase = "all_request";
    for (int i = 0; i < 17; i++) cycle(4'b1111, 3'($urandom_range(0, 7)));

    phase = "short_burst";
    cycle(4'b0000, 3'b000);
    cycle(4'b0000, 3'b000);
    cycle(4'b0100, 3'b100);
    cycle(4'b0100, 3'b100);
    cycle(4'b0000, 3'b000);
    cycle(4'b0000, 3'b000);

    phase = "saturate";
    for (int i = 0; i < 10; i++) cycle(4'b0010, 3'b010);
    cycle(4'b1010, 3'b011);
    cycle(4'b1010, 3'b011);

    phase = "drop_handover";
    cycle(4'b0000, 3'b000);
    cycle(4'b0000, 3'b000);
    cycle(4'b0001, 3'b001);
    cycle(4'b0110, 3'b110);
    cycle(4'b0110, 3'b110);

    phase = "async_reset";
    #2;
    rst  = 1'b1;
    req4 = '0;
    req3 = '0;
    #1;
    chk("arst_grant4", 32'(grant4), 32'd0);
    chk("arst_valid4", 32'(valid4), 32'd0);
    chk("arst_grant3", 32'(grant3), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(4'b1010, 3'b110);
    cycle(4'b1010, 3'b110);

    phase = "random";
    r4 = '0;
    r3 = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r3 = 3'($urandom_range(0, 7));
      cycle(r4, r3);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
